ew_pattern_gen: RTL
===================

EW_PATTERN_GEN -- requirements
Module: ew_pattern_gen

Interface
REQ-001 SHALL have port serdesclk, input, 1: sole clock; all state rises on posedge.
REQ-002 SHALL have port serdes_reset, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port pattern_en, input, 1: level; 1 = generator may run.
REQ-004 SHALL have port axi_start_on_serdesclk, input, 1: one-cycle start pulse; arms the generator and clears the tag.
REQ-005 SHALL have port ewm, input, 1: one-cycle event-window marker.
REQ-006 SHALL have port hit_count, input, 8: hit words per window, sampled on the accepted ewm.
REQ-007 SHALL have port ew_fifo_full, input, 1: backpressure; while 1, no write occurs.
REQ-008 SHALL have port curr_ewfifo_wr, output, 1: ping-pong buffer select.
REQ-009 SHALL have port ew_done, output, 1: one-cycle end-of-window pulse.
REQ-010 SHALL have port ew_ovfl, output, 1: overflow flag, valid with ew_done.
REQ-011 SHALL have port ew_fifo_we, output, 1: write strobe.
REQ-012 SHALL have port ew_fifo_data, output, `DIGI_BITS (>=32): write data.
REQ-013 SHALL have port ew_size, output, `EVENT_SIZE_BITS: window size in 64-bit beats, valid with ew_done.
REQ-014 SHALL have port ew_tag, output, `SPILL_TAG_BITS: tag of the current window.

Function
REQ-015 SHALL implement states IDLE, ARMED, WRITE, DONE.
REQ-016 IDLE->ARMED SHALL occur on axi_start_on_serdesclk=1 with pattern_en=1; the same edge SHALL load the tag counter to 0.
REQ-017 ARMED+ewm SHALL do all of: latch hit_count as N, set ew_tag to the tag counter, toggle curr_ewfifo_wr, clear the word index, clear ew_ovfl, go to WRITE.
REQ-018 In WRITE, each cycle with ew_fifo_full=0 SHALL assert ew_fifo_we, present word[index], and increment the index.
REQ-019 With ew_fifo_full=1, ew_fifo_we SHALL be 0 and the index SHALL hold.
REQ-020 Hit word k SHALL have data[15:0]=k and data[31:16]=ew_tag (zero-extended/truncated); all bits above 31 SHALL be 0.
REQ-021 WRITE->DONE SHALL occur on the cycle after the last word is written; N=0 SHALL go to DONE with no writes.
REQ-022 DONE SHALL last 1 cycle and do all of: pulse ew_done, present ew_size=(W+1)>>1 where W = total words written, increment the tag counter (modulo 2^`SPILL_TAG_BITS), return to ARMED (or to IDLE if pattern_en=0).
REQ-023 An ewm in WRITE or DONE SHALL be dropped, SHALL set ew_ovfl sticky until the next ew_done, and SHALL increment the tag counter once per dropped marker.
REQ-024 An ewm in ARMED on the same cycle as DONE's return SHALL NOT be possible; DONE SHALL always consume one cycle.
REQ-025 pattern_en=0 in ARMED SHALL go to IDLE; in WRITE, the current window SHALL complete first.
REQ-026 axi_start_on_serdesclk outside IDLE SHALL be ignored.

Reset
REQ-027 serdes_reset=1 SHALL immediately force: state IDLE, curr_ewfifo_wr=0, ew_done=0, ew_ovfl=0, ew_fifo_we=0, ew_fifo_data=0, ew_size=0, ew_tag=0, tag counter 0, index 0.
REQ-028 Reset mid-window SHALL abandon the window with no ew_done.

Configuration
REQ-029 With macro PATTERN_HEADER_EN defined, each window SHALL write one header word {data[31:16]=ew_tag, data[15:0]=16'hEEEE} before the hit words, giving W=N+1; with the macro undefined, there is no header and W=N.

Verification
REQ-030 Start, ewm, hit_count=4, no full (no header) -> 4 writes of data 0x00000000..0x00000003, then ew_done with ew_size=2, tag=0, curr_ewfifo_wr=1.
REQ-031 Second window with hit_count=3 -> data 0x00010000..0x00010002, ew_size=2, ew_tag=1, curr_ewfifo_wr=0.
REQ-032 hit_count=0 -> no ew_fifo_we; ew_done with ew_size=0 two cycles after the ewm.
REQ-033 ew_fifo_full held 5 cycles mid-window -> no write during those cycles, index held, all N words delivered in order.
REQ-034 Extra ewm during WRITE -> ew_ovfl=1 at ew_done; the next window's ew_tag is the previous tag+2.
REQ-035 PATTERN_HEADER_EN defined, hit_count=2 -> 3 writes, first word 0x0000EEEE, ew_size=2; serdes_reset asserted mid-window -> all outputs 0 at once.

Source files
------------

// File: rtl/ew_pattern_gen.sv
// ew_pattern_gen -- event-window test-pattern generator.
//
// Once started, waits for an event-window marker (ewm). Each accepted marker
// opens a window of hit_count hit words that are written into the event-window
// FIFO. Writes stall while the FIFO reports full. Each window finishes with a
// one-cycle ew_done pulse carrying the window size in 64-bit beats.
//
// Ports:
//   serdesclk              sole clock, all state on posedge
//   serdes_reset           asynchronous active-high reset
//   pattern_en             level enable; 0 parks the generator in IDLE
//   axi_start_on_serdesclk one-cycle start pulse (IDLE only); zeroes the tag counter
//   ewm                    one-cycle event-window marker
//   hit_count[7:0]         hit words per window, sampled with the accepted ewm
//   ew_fifo_full           backpressure; no write while high
//   curr_ewfifo_wr         ping-pong buffer select, toggles on every accepted window
//   ew_done                one-cycle end-of-window pulse
//   ew_ovfl                markers were dropped during this window (valid with ew_done)
//   ew_fifo_we             write strobe
//   ew_fifo_data           write data: {0.., tag[15:0], word index/header}
//   ew_size                window size in 64-bit beats (valid with ew_done)
//   ew_tag                 tag of the current window
//
// Configuration:
//   PATTERN_HEADER_EN      when defined, each window starts with a header word
//                          {tag, 16'hEEEE}
//   DIGI_BITS, EVENT_SIZE_BITS, SPILL_TAG_BITS set the output widths (defaulted here).

`ifndef DIGI_BITS
`define DIGI_BITS 32
`endif
`ifndef EVENT_SIZE_BITS
`define EVENT_SIZE_BITS 16
`endif
`ifndef SPILL_TAG_BITS
`define SPILL_TAG_BITS 8
`endif

module ew_pattern_gen (
  input  logic                          serdesclk,
  input  logic                          serdes_reset,
  input  logic                          pattern_en,
  input  logic                          axi_start_on_serdesclk,
  input  logic                          ewm,
  input  logic [7:0]                    hit_count,
  input  logic                          ew_fifo_full,
  output logic                          curr_ewfifo_wr,
  output logic                          ew_done,
  output logic                          ew_ovfl,
  output logic                          ew_fifo_we,
  output logic [`DIGI_BITS-1:0]         ew_fifo_data,
  output logic [`EVENT_SIZE_BITS-1:0]   ew_size,
  output logic [`SPILL_TAG_BITS-1:0]    ew_tag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                        state_q, state_d;
  logic [7:0]                    n_q, n_d;
  logic [8:0]                    idx_q, idx_d;
  logic [`SPILL_TAG_BITS-1:0]    tag_cnt_q, tag_cnt_d;
  logic [`SPILL_TAG_BITS-1:0]    ew_tag_q, ew_tag_d;
  logic                          wr_sel_q, wr_sel_d;
  logic                          done_q, done_d;
  logic                          ovfl_q, ovfl_d;
  logic                          we_q, we_d;
  logic [`DIGI_BITS-1:0]         data_q, data_d;
  logic [`EVENT_SIZE_BITS-1:0]   size_q, size_d;

  // Total words in the window (hit words plus optional header) and the
  // content of the word at the current index.
  logic [8:0]                    total_words;
  logic [9:0]                    words_plus1;
  logic [`DIGI_BITS-1:0]         cur_word;

  always_comb begin
`ifdef PATTERN_HEADER_EN
    total_words = {1'b0, n_q} + 9'd1;
`else
    total_words = {1'b0, n_q};
`endif
    words_plus1 = {1'b0, idx_q} + 10'd1;

    cur_word        = '0;
    cur_word[31:16] = 16'(ew_tag_q);
`ifdef PATTERN_HEADER_EN
    // Index 0 is the header; hit word k sits at index k+1.
    if (idx_q == 9'd0) cur_word[15:0] = 16'hEEEE;
    else               cur_word[15:0] = 16'(idx_q - 9'd1);
`else
    cur_word[15:0] = 16'(idx_q);
`endif
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    tag_cnt_d = tag_cnt_q;
    ew_tag_d  = ew_tag_q;
    wr_sel_d  = wr_sel_q;
    done_d    = 1'b0;
    ovfl_d    = ovfl_q;
    we_d      = 1'b0;
    data_d    = data_q;
    size_d    = size_q;

    unique case (state_q)
      IDLE: begin
        if (axi_start_on_serdesclk && pattern_en) begin
          state_d   = ARMED;
          tag_cnt_d = '0;
          ew_tag_d  = '0;
        end
      end

      ARMED: begin
        if (!pattern_en) begin
          state_d = IDLE;
        end else if (ewm) begin
          state_d  = WRITE;
          n_d      = hit_count;
          ew_tag_d = tag_cnt_q;
          wr_sel_d = ~wr_sel_q;
          idx_d    = '0;
          ovfl_d   = 1'b0;
        end
      end

      WRITE: begin
        if (ewm) begin
          ovfl_d    = 1'b1;
          tag_cnt_d = tag_cnt_q + 1'b1;
        end
        // idx counts words already written, so it equals W once the window
        // is complete; DONE follows the cycle the last write is visible.
        if (idx_q == total_words) begin
          state_d = DONE;
          done_d  = 1'b1;
          size_d  = `EVENT_SIZE_BITS'(words_plus1 >> 1);
        end else if (!ew_fifo_full) begin
          we_d   = 1'b1;
          data_d = cur_word;
          idx_d  = idx_q + 9'd1;
        end
      end

      DONE: begin
        // End-of-window increment plus one more for a marker dropped here.
        tag_cnt_d = tag_cnt_q + 1'b1 + (ewm ? 1'b1 : 1'b0);
        if (ewm) ovfl_d = 1'b1;
        state_d = pattern_en ? ARMED : IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge serdesclk or posedge serdes_reset) begin
    if (serdes_reset) begin
      state_q   <= IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      tag_cnt_q <= '0;
      ew_tag_q  <= '0;
      wr_sel_q  <= 1'b0;
      done_q    <= 1'b0;
      ovfl_q    <= 1'b0;
      we_q      <= 1'b0;
      data_q    <= '0;
      size_q    <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      tag_cnt_q <= tag_cnt_d;
      ew_tag_q  <= ew_tag_d;
      wr_sel_q  <= wr_sel_d;
      done_q    <= done_d;
      ovfl_q    <= ovfl_d;
      we_q      <= we_d;
      data_q    <= data_d;
      size_q    <= size_d;
    end
  end

  assign curr_ewfifo_wr = wr_sel_q;
  assign ew_done        = done_q;
  assign ew_ovfl        = ovfl_q;
  assign ew_fifo_we     = we_q;
  assign ew_fifo_data   = data_q;
  assign ew_size        = size_q;
  assign ew_tag         = ew_tag_q;

endmodule
